key_conditioner: RTL and testbench



---
 rtl/key_conditioner_pkg.sv | 16 +
 rtl/key_debounce_fsm.sv | 133 +++++++++++++
 rtl/key_conditioner.sv | 34 +++
 tb/tb_key_conditioner.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/key_conditioner_pkg.sv
// Shared definitions for the push-button conditioning front end:
// per-key debounce state encoding and the default 50 MHz cycle constants.
package key_conditioner_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_PEND   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_PEND = 2'd3
    } key_state_e;

    // 10 ms debounce window and 1 s long-press threshold at 50 MHz
    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    localparam int DEF_HOLD_CYCLES     = 50000000;

endpackage

// File: rtl/key_debounce_fsm.sv
// One key: 2-flop synchronizer, debounce FSM sharing a single counter for
// the debounce window and the long-press timer, registered event pulses.
module key_debounce_fsm
    import key_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key_n,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_hold
);

    localparam int CW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] DEB_MAX  = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] HOLD_MAX = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] ONE      = CW'(1);

    logic          r_sync1;
    logic          r_sync2;
    logic          w_s;
    key_state_e    r_state;
    key_state_e    w_state_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic          w_press;
    logic          w_release;
    logic          w_hold;
    logic          w_level;
    logic          r_level;
    logic          r_press;
    logic          r_release;
    logic          r_hold;

    assign w_s = ~r_sync2;

    // Synchronizer resets to "released" so a held key after reset is seen as a fresh press
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_press      = 1'b0;
        w_release    = 1'b0;
        w_hold       = 1'b0;
        unique case (r_state)
            RELEASED: begin
                if (w_s) begin
                    w_state_next = PRESS_PEND;
                    w_cnt_next   = ONE;
                end else begin
                    w_cnt_next   = '0;
                end
            end
            PRESS_PEND: begin
                if (!w_s) begin
                    w_state_next = RELEASED;
                    w_cnt_next   = '0;
                end else if (r_cnt == DEB_MAX) begin
                    w_state_next = PRESSED;
                    w_cnt_next   = '0;
                    w_press      = 1'b1;
                end else begin
                    w_cnt_next   = r_cnt + ONE;
                end
            end
            PRESSED: begin
                if (!w_s) begin
                    w_state_next = RELEASE_PEND;
                    w_cnt_next   = ONE;
                end else if (r_cnt != HOLD_MAX) begin
                    // Saturates at HOLD_MAX, so the long-press pulse fires once
                    w_cnt_next   = r_cnt + ONE;
                    w_hold       = (r_cnt == HOLD_MAX - ONE);
                end
            end
            RELEASE_PEND: begin
                if (w_s) begin
                    w_state_next = PRESSED;
                    w_cnt_next   = '0;
                end else if (r_cnt == DEB_MAX) begin
                    w_state_next = RELEASED;
                    w_cnt_next   = '0;
                    w_release    = 1'b1;
                end else begin
                    w_cnt_next   = r_cnt + ONE;
                end
            end
            default: begin
                w_state_next = RELEASED;
                w_cnt_next   = '0;
            end
        endcase
    end

    assign w_level = (w_state_next == PRESSED) || (w_state_next == RELEASE_PEND);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= RELEASED;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_hold    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_level   <= w_level;
            r_press   <= w_press;
            r_release <= w_release;
            r_hold    <= w_hold;
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_hold    = r_hold;

endmodule

// File: rtl/key_conditioner.sv
// Board push-button front end: one independent debounce channel per
// active-low KEY_N input, producing clean levels and event pulses.
module key_conditioner
    import key_conditioner_pkg::*;
#(
    parameter int N_KEYS          = 2,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES
) (
    input  logic              CLK_50MHZ,
    input  logic              RST,
    input  logic [N_KEYS-1:0] KEY_N,
    output logic [N_KEYS-1:0] KEY_LEVEL,
    output logic [N_KEYS-1:0] KEY_PRESS,
    output logic [N_KEYS-1:0] KEY_RELEASE,
    output logic [N_KEYS-1:0] KEY_HOLD
);

    for (genvar g = 0; g < N_KEYS; g++) begin : g_key
        key_debounce_fsm #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES)
        ) u_key (
            .i_clk     (CLK_50MHZ),
            .i_rst     (RST),
            .i_key_n   (KEY_N[g]),
            .o_level   (KEY_LEVEL[g]),
            .o_press   (KEY_PRESS[g]),
            .o_release (KEY_RELEASE[g]),
            .o_hold    (KEY_HOLD[g])
        );
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed plus randomized bench for key_conditioner with a run-length
// reference model of the debounce and long-press rules.
module tb_key_conditioner;

    localparam int N = 2;
    localparam int D = 4;
    localparam int H = 20;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] key_n;
    logic [N-1:0] level;
    logic [N-1:0] press;
    logic [N-1:0] rel;
    logic [N-1:0] hold;

    key_conditioner #(
        .N_KEYS          (N),
        .DEBOUNCE_CYCLES (D),
        .HOLD_CYCLES     (H)
    ) dut (
        .CLK_50MHZ   (clk),
        .RST         (rst),
        .KEY_N       (key_n),
        .KEY_LEVEL   (level),
        .KEY_PRESS   (press),
        .KEY_RELEASE (rel),
        .KEY_HOLD    (hold)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: accepted level flips once the pressed-ness seen by the
    // key logic disagrees with it for D+1 consecutive edges; the long-press
    // timer counts agreeing edges since acceptance or since a release glitch.
    logic [N-1:0] e_level, e_press, e_rel, e_hold;
    int           dis [N];
    int           hc  [N];
    logic [N-1:0] h1, h2;

    task automatic model_reset();
        e_level = '0; e_press = '0; e_rel = '0; e_hold = '0;
        for (int i = 0; i < N; i++) begin
            dis[i] = 0;
            hc[i]  = 0;
        end
        h1 = '1;
        h2 = '1;
    endtask

    task automatic model_edge();
        logic s;
        e_press = '0; e_rel = '0; e_hold = '0;
        for (int i = 0; i < N; i++) begin
            s = ~h2[i];
            if (s != e_level[i]) begin
                dis[i]++;
                if (dis[i] == D + 1) begin
                    e_level[i] = s;
                    dis[i] = 0;
                    if (s) begin
                        e_press[i] = 1'b1;
                        hc[i] = 0;
                    end else begin
                        e_rel[i] = 1'b1;
                    end
                end else if (e_level[i]) begin
                    hc[i] = -1;
                end
            end else begin
                dis[i] = 0;
                if (e_level[i]) begin
                    if (hc[i] < 0) begin
                        hc[i] = 0;
                    end else if (hc[i] < H) begin
                        hc[i]++;
                        if (hc[i] == H) e_hold[i] = 1'b1;
                    end
                end
            end
        end
        h2 = h1;
        h1 = key_n;
    endtask

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_level"}, level, '0);
        check({tag, "_press"}, press, '0);
        check({tag, "_release"}, rel, '0);
        check({tag, "_hold"}, hold, '0);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check("level", level, e_level);
        check("press", press, e_press);
        check("release", rel, e_rel);
        check("hold", hold, e_hold);
    endtask

    initial begin
        int           n;
        int           dur [N];
        logic [N-1:0] seen;

        rst   = 1'b1;
        key_n = '1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;

        // Clean press on key 0: first low sample is edge 1, press on edge 7
        key_n[0] = 1'b0;
        n = 0;
        do begin step(); n++; end while (press[0] !== 1'b1 && n < 40);
        check_int("press_latency", n, 7);
        n = 0;
        do begin step(); n++; end while (hold[0] !== 1'b1 && n < 40);
        check_int("hold_latency", n, H);
        repeat (3) step();

        // Clean release of key 0
        key_n[0] = 1'b1;
        n = 0;
        do begin step(); n++; end while (rel[0] !== 1'b1 && n < 40);
        check_int("release_latency", n, 7);
        repeat (8) step();

        // Bounce on key 1: 3-cycle runs never reach the acceptance window
        seen = '0;
        for (int c = 0; c < 30; c++) begin
            key_n[1] = ((c / 3) % 2 == 0) ? 1'b0 : 1'b1;
            step();
            seen[1] = seen[1] | level[1] | press[1] | rel[1] | hold[1];
        end
        key_n[1] = 1'b1;
        repeat (10) begin
            step();
            seen[1] = seen[1] | level[1] | press[1] | rel[1] | hold[1];
        end
        check("bounce_quiet", seen, '0);

        // Short press and release, no hold expected
        key_n[0] = 1'b0;
        repeat (10) step();
        key_n[0] = 1'b1;
        repeat (12) step();

        // Release glitch: two high samples while pressed
        key_n[0] = 1'b0;
        repeat (12) step();
        key_n[0] = 1'b1;
        repeat (2) step();
        key_n[0] = 1'b0;
        n = 0;
        do begin step(); n++; end while (hold[0] !== 1'b1 && n < 60);
        // key logic returns to pressed 2 edges after the first low sample, then H edges
        check_int("glitch_hold_latency", n, H + 3);
        key_n[0] = 1'b1;
        repeat (12) step();

        // Simultaneous press on both keys
        key_n = '0;
        n = 0;
        do begin step(); n++; end while (press === '0 && n < 40);
        check("simul_press", press, 2'b11);
        check_int("simul_latency", n, 7);
        key_n = '1;
        repeat (12) step();

        // Reset while key 0 is accepted and still held
        key_n[0] = 1'b0;
        repeat (10) step();
        check("pre_reset_level", level, 2'b01);
        #2;
        rst = 1'b1;
        #1;
        check_zero("async_reset");
        model_reset();
        @(posedge clk);
        #1;
        check_zero("reset_hold");
        rst = 1'b0;
        n = 0;
        do begin step(); n++; end while (press[0] !== 1'b1 && n < 40);
        check_int("post_reset_press_latency", n, 7);
        key_n[0] = 1'b1;
        repeat (12) step();

        // Randomized key activity
        for (int i = 0; i < N; i++) dur[i] = 0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (dur[i] == 0) begin
                    key_n[i] = 1'($urandom_range(0, 1));
                    dur[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(18, 32))
                                                         : int'($urandom_range(1, 8));
                end
                dur[i]--;
            end
            step();
        end
        key_n = '1;
        repeat (15) step();
        check("final_idle_level", level, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
